interrupt_timer: RTL and testbench

Programmable down-counting timer that raises a hardware interrupt line toward the coprocessor's HWInt inputs. It is a memory-mapped peripheral on the CPU data bus. Software writes a preset value and a control word, and the timer counts down and asserts irq on expiry. It supports one-shot and auto-reload modes, and a mask bit that gates irq.

---
 rtl/interrupt_timer_if.sv | 10 +
 rtl/interrupt_timer.sv | 97 +++++++++
 tb/tb_interrupt_timer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_timer_if.sv
// CPU data-bus port of the interrupt timer: address/write strobe/data in, combinational read data out.
interface interrupt_timer_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, we, din, input dout);
  modport slave  (input addr, we, din, output dout);
endinterface

// File: rtl/interrupt_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a masked interrupt line.
module interrupt_timer (
  input  logic               clk,
  input  logic               reset,
  interrupt_timer_if.slave   bus,
  output logic               irq
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_flag, flag_nxt;
  logic        en_clr;
  logic [1:0]  sel;
  logic        en;
  logic [1:0]  mode;
  logic        unused_addr;

  assign sel         = bus.addr[3:2];
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};
  assign en          = ctrl[0];
  assign mode        = ctrl[2:1];
  assign irq         = ctrl[3] & irq_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_nxt  = irq_flag;
    en_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          flag_nxt  = 1'b0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = 32'd0;
          state_nxt = S_INT;
        end
      end
      S_INT: begin
        flag_nxt  = 1'b1;
        state_nxt = S_IDLE;
        en_clr    = (mode == 2'd0);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A bus write to CTRL in the INT cycle takes precedence over the one-shot clear of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      count    <= count_nxt;
      irq_flag <= flag_nxt;
      if (bus.we && sel == 2'd0)  ctrl   <= bus.din[3:0];
      else if (en_clr)            ctrl[0] <= 1'b0;
      if (bus.we && sel == 2'd1)  preset <= bus.din;
    end
  end

  always_comb begin
    bus.dout = 32'd0;
    case (sel)
      2'd0:    bus.dout = {28'd0, ctrl};
      2'd1:    bus.dout = preset;
      2'd2:    bus.dout = count;
      default: bus.dout = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_interrupt_timer.sv
// Directed and random bus traffic against a timeline-based reference model of the interrupt timer.
`timescale 1ns/100ps
module tb_interrupt_timer;
  logic clk = 1'b0;
  logic reset;
  logic irq;
  int   errors = 0;
  int   checks = 0;

  interrupt_timer_if bus ();

  interrupt_timer dut (.clk(clk), .reset(reset), .bus(bus), .irq(irq));

  always #10 clk = ~clk;

  // Reference model: a run is described by the edge at which count was loaded
  // (m_t0) and the loaded length (m_L); count and expiry follow arithmetically.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_L;
  logic        m_flag;
  int          m_stage;   // 0 waiting, 1 loading, 2 running, 3 expired
  longint      m_now, m_t0;

  task automatic model_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_L = 32'd0;
    m_flag = 1'b0; m_stage = 0; m_t0 = 0;
  endtask

  task automatic model_step(input logic w, input logic [1:0] a, input logic [31:0] d);
    longint el, lim;
    logic   clr;
    clr = 1'b0;
    case (m_stage)
      0: if (m_ctrl[0]) begin m_flag = 1'b0; m_stage = 1; end
      1: begin m_L = m_preset; m_t0 = m_now + 1; m_count = m_preset; m_stage = 2; end
      2: begin
        if (!m_ctrl[0]) m_stage = 0;
        else begin
          el  = m_now + 1 - m_t0;
          lim = (m_L == 32'd0) ? 64'd1 : longint'(m_L);
          if (el >= lim) begin m_count = 32'd0; m_stage = 3; end
          else m_count = m_L - 32'(el);
        end
      end
      default: begin m_flag = 1'b1; m_stage = 0; clr = (m_ctrl[2:1] == 2'd0); end
    endcase
    if (w && a == 2'd0) m_ctrl = d[3:0];
    else if (clr)       m_ctrl[0] = 1'b0;
    if (w && a == 2'd1) m_preset = d;
    m_now++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.we   = 1'b0;
    bus.addr = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
    #1;
    v = bus.dout;
  endtask

  task automatic check_all();
    logic [31:0] v;
    chk("irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
    rd(2'd0, v); chk("ctrl", v, {28'd0, m_ctrl});
    rd(2'd1, v); chk("preset", v, m_preset);
    rd(2'd2, v); chk("count", v, m_count);
    rd(2'd3, v); chk("unused", v, 32'd0);
  endtask

  task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d);
    bus.we   = w;
    bus.addr = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
    bus.din  = d;
    @(posedge clk);
    model_step(w, a, d);
    #1;
    bus.we = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0);
  endtask

  task automatic async_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          pulses;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    m_now = 0;
    bus.addr = 32'd0; bus.we = 1'b0; bus.din = 32'd0;
    reset = 1'b1;
    model_reset();
    #2;
    check_all();
    reset = 1'b0;

    // reset mid-count
    cycle(1'b1, 2'd1, 32'd10);
    cycle(1'b1, 2'd0, 32'h9);
    idle(4);
    async_reset();

    // one-shot, preset 5
    cycle(1'b1, 2'd1, 32'd5);
    cycle(1'b1, 2'd0, 32'h9);
    idle(7);
    chk("os_irq_e7", {31'd0, irq}, 32'd0);
    idle(1);
    chk("os_irq_e8", {31'd0, irq}, 32'd1);
    rd(2'd0, v); chk("os_ctrl", v, 32'h8);
    idle(20);
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    cycle(1'b1, 2'd0, 32'h9);
    chk("os_irq_wr", {31'd0, irq}, 32'd1);
    idle(1);
    chk("os_irq_drop", {31'd0, irq}, 32'd0);
    idle(10);

    // auto-reload, preset 3: period 6
    cycle(1'b1, 2'd1, 32'd3);
    cycle(1'b1, 2'd0, 32'hB);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (irq) pulses++;
    end
    chk("auto_pulses", 32'(pulses), 32'd5);
    cycle(1'b1, 2'd0, 32'h0);
    idle(8);

    // masking
    cycle(1'b1, 2'd1, 32'd2);
    cycle(1'b1, 2'd0, 32'h1);
    idle(10);
    cycle(1'b1, 2'd0, 32'h8);
    chk("mask_pending", {31'd0, irq}, 32'd1);

    // disable mid-count
    cycle(1'b1, 2'd1, 32'd100);
    cycle(1'b1, 2'd0, 32'h1);
    idle(8);
    cycle(1'b1, 2'd0, 32'h0);
    idle(5);
    rd(2'd2, v); chk("dis_frozen", v, 32'd93);
    cycle(1'b1, 2'd2, 32'd7);
    rd(2'd2, v); chk("dis_count_ro", v, 32'd93);
    chk("dis_no_irq", {31'd0, irq}, 32'd0);

    // collision: CTRL write in the INT cycle keeps en
    cycle(1'b1, 2'd1, 32'd1);
    cycle(1'b1, 2'd0, 32'h9);
    idle(3);
    cycle(1'b1, 2'd0, 32'h9);
    rd(2'd0, v); chk("col_ctrl", v, 32'h9);
    chk("col_irq", {31'd0, irq}, 32'd1);
    idle(6);
    cycle(1'b1, 2'd0, 32'h0);
    idle(6);

    // preset 0 reaches INT at E3
    cycle(1'b1, 2'd1, 32'd0);
    cycle(1'b1, 2'd0, 32'h9);
    idle(3);
    chk("p0_irq_e3", {31'd0, irq}, 32'd0);
    idle(1);
    chk("p0_irq_e4", {31'd0, irq}, 32'd1);

    // random traffic with occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0:    d = 32'($urandom_range(0, 15));
        2'd1:    d = 32'($urandom_range(0, 7));
        default: d = $urandom();
      endcase
      cycle(w, a, d);
      if ($urandom_range(0, 63) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
